// File: rtl/j_uart_pkg.sv
// Shared constants and state encoding for the Jerry UART receive/transmit pair.
package j_uart_pkg;
   localparam int OVERSAMPLE     = 16;
   localparam int MID_SAMPLE     = OVERSAMPLE / 2 - 1;
   localparam int DATA_BITS      = 8;
   localparam int START_BITS     = 1;
   localparam int STOP_BITS      = 1;
   localparam int FRAME_BITS     = START_BITS + DATA_BITS + STOP_BITS;
   localparam int FRAME_BITS_PAR = FRAME_BITS + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAITHI
   } rx_state_t;
endpackage

// File: rtl/j_rxsync.sv
// Multi-flop synchroniser for the serial pin; resets to mark so a reset line looks idle.
module j_rxsync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic serin,
   input  logic rxpol,
   output logic rxd
);
   logic [STAGES-1:0] sync;

   always_ff @(posedge clk) begin
      if (reset) sync <= '1;
      else       sync <= (sync << 1) | STAGES'(serin);
   end

   assign rxd = sync[STAGES-1] ^ rxpol;
endmodule

// File: rtl/j_rxer.sv
// Jerry UART receiver: 16x oversampled deframer with sticky error flags and live break.
//   state  | meaning
//   IDLE   | line at mark, watching for a start edge
//   START  | confirming start bit at its mid-point
//   DATA   | sampling data bits one bit period apart, LSB first
//   PARITY | sampling the parity bit
//   STOP   | sampling the stop bit, delivering the byte
//   WAITHI | line stuck low after stop; wait for mark before re-arming
module j_rxer #(
   parameter int DATA_BITS   = j_uart_pkg::DATA_BITS,
   parameter int OVERSAMPLE  = j_uart_pkg::OVERSAMPLE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serin,
   input  logic                 rxpol,
   input  logic                 bx16,
   input  logic                 paren,
   input  logic                 even,
   input  logic                 u2drd,
   input  logic                 clrerr,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rbf,
   output logic                 perr,
   output logic                 ferr,
   output logic                 oe,
   output logic                 rxbrk
);
   import j_uart_pkg::*;

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(MID_SAMPLE);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   rx_state_t state, state_nxt;
   logic                 rxd;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bcnt;
   logic [DATA_BITS-1:0] shift;
   logic                 pbit;
   logic                 at_last, par_err, load;
   logic                 cnt_clr, shift_en, pbit_en, done, brk_clr;

   j_rxsync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .serin (serin),
      .rxpol (rxpol),
      .rxd   (rxd)
   );

   assign at_last = bx16 && (cnt == CNT_LAST);
   assign par_err = paren && (pbit != (^shift ^ ~even));
   // A read landing on the completion cycle frees the buffer in time for the new byte.
   assign load    = !rbf || u2drd;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bx16 && !rxd) state_nxt = START;
         START:   if (bx16 && cnt == CNT_MID) state_nxt = rxd ? IDLE : DATA;
         DATA:    if (at_last && bcnt == BIT_LAST) state_nxt = paren ? PARITY : STOP;
         PARITY:  if (at_last) state_nxt = STOP;
         STOP:    if (at_last) state_nxt = rxd ? IDLE : WAITHI;
         WAITHI:  if (bx16 && rxd) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_clr  = 1'b0;
      shift_en = 1'b0;
      pbit_en  = 1'b0;
      done     = 1'b0;
      brk_clr  = 1'b0;
      case (state)
         IDLE:    cnt_clr  = bx16 && !rxd;
         START:   cnt_clr  = bx16 && cnt == CNT_MID;
         DATA:    shift_en = at_last;
         PARITY:  pbit_en  = at_last;
         STOP:    done     = at_last;
         WAITHI:  brk_clr  = bx16 && rxd;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         bcnt  <= '0;
         shift <= '0;
         pbit  <= 1'b0;
         dout  <= '0;
         rbf   <= 1'b0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
         oe    <= 1'b0;
         rxbrk <= 1'b0;
      end else begin
         if (cnt_clr)   cnt <= '0;
         else if (bx16) cnt <= cnt + 1'b1;
         if (cnt_clr)       bcnt <= '0;
         else if (shift_en) bcnt <= bcnt + 1'b1;
         if (shift_en) shift <= {rxd, shift[DATA_BITS-1:1]};
         if (pbit_en)  pbit  <= rxd;

         if (done && load) begin
            dout <= shift;
            rbf  <= 1'b1;
         end else if (u2drd) begin
            rbf  <= 1'b0;
         end

         // Set terms dominate clrerr so an error in the clear cycle is not lost.
         oe   <= (oe   && !clrerr) || (done && !load);
         ferr <= (ferr && !clrerr) || (done && !rxd);
         perr <= (perr && !clrerr) || (done && par_err);

         if (done)         rxbrk <= (shift == '0) && (!pbit || !paren) && !rxd;
         else if (brk_clr) rxbrk <= 1'b0;
      end
   end
endmodule

// File: tb/tb_j_rxer.sv
// Self-checking bench for j_rxer: directed scenarios plus random frames against a frame-level model.
module tb_j_rxer;
   localparam int OS   = 16;
   localparam int NB   = 8;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset, serin, rxpol, bx16, paren, even, u2drd, clrerr;
   logic [7:0] dout;
   logic       rbf, perr, ferr, oe, rxbrk;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_dout;
   logic       m_rbf, m_perr, m_ferr, m_oe, m_brk;

   j_rxer #(.DATA_BITS(NB), .OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
      .clk    (clk),
      .reset  (reset),
      .serin  (serin),
      .rxpol  (rxpol),
      .bx16   (bx16),
      .paren  (paren),
      .even   (even),
      .u2drd  (u2drd),
      .clrerr (clrerr),
      .dout   (dout),
      .rbf    (rbf),
      .perr   (perr),
      .ferr   (ferr),
      .oe     (oe),
      .rxbrk  (rxbrk)
   );

   always #5 clk = ~clk;

   // Frame-relative clock index whose edge samples mid stop bit (bx16 every clk):
   // sync delay, detect edge, half a start bit, then whole start/data/parity periods.
   function automatic int done_idx(input bit par);
      return SYNC + j_uart_pkg::MID_SAMPLE + 1 + OS * (NB + 1 + int'(par));
   endfunction

   function automatic bit good_parity(input logic [7:0] d, input bit ev);
      bit odd_ones;
      odd_ones = ($countones(d) % 2) == 1;
      return ev ? odd_ones : !odd_ones;
   endfunction

   task automatic model_reset();
      m_dout = 8'h00; m_rbf = 0; m_perr = 0; m_ferr = 0; m_oe = 0; m_brk = 0;
   endtask

   task automatic model_done(input logic [7:0] d, input bit par, input bit ev, input bit pb,
                             input bit stop, input bit rd_same);
      if (!m_rbf || rd_same) begin
         m_dout = d;
         m_rbf  = 1;
      end else begin
         m_oe = 1;
      end
      if (!stop) m_ferr = 1;
      if (par && pb != good_parity(d, ev)) m_perr = 1;
      m_brk = (d == 8'h00) && (!par || !pb) && !stop;
   endtask

   task automatic idle(input int n);
      bx16 = 1; u2drd = 0; clrerr = 0; reset = 0;
      repeat (n) begin
         serin = 1'b1 ^ rxpol;
         @(negedge clk);
      end
   endtask

   task automatic do_read();
      u2drd = 1;
      @(negedge clk);
      u2drd = 0;
      m_rbf = 0;
   endtask

   task automatic do_clr();
      clrerr = 1;
      @(negedge clk);
      clrerr = 0;
      m_perr = 0; m_ferr = 0; m_oe = 0;
   endtask

   // One frame driven a clock at a time; bx16 pulses every div clocks.
   task automatic send_frame(input logic [7:0] d, input bit par, input bit pb, input bit stop,
                             input int div, input int rd_at, input int rst_at,
                             output int rise_at, output logic [8:0] snap);
      logic line [0:10];
      int   nbits, per, total;
      logic prev;
      nbits = par ? 11 : 10;
      per   = OS * div;
      total = nbits * per;
      line[0] = 1'b0;
      for (int i = 0; i < 8; i++) line[i+1] = d[i];
      line[9]  = par ? pb : stop;
      line[10] = stop;
      rise_at = -1;
      snap    = '0;
      prev    = rbf;
      for (int c = 0; c < total; c++) begin
         serin = line[c/per] ^ rxpol;
         bx16  = (c % div) == 0;
         u2drd = (c == rd_at);
         reset = (c == rst_at);
         @(negedge clk);
         if (rbf && !prev && rise_at < 0) rise_at = c;
         if (c == rst_at) snap = {dout, rbf};
         prev = rbf;
      end
      bx16 = 1; u2drd = 0; reset = 0;
      serin = 1'b1 ^ rxpol;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) @(negedge clk);
      reset = 0;
      model_reset();
      checks++;
      if (dout !== m_dout) begin
         errors++; $display("FAIL reset_dout: got %h exp %h", dout, m_dout);
      end
      checks++;
      if ({rbf, perr, ferr, oe, rxbrk} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b exp 00000", {rbf, perr, ferr, oe, rxbrk});
      end
      idle(20);
   endtask

   task automatic test_basic();
      int r; logic [8:0] s;
      paren = 0; even = 0;
      send_frame(8'hA5, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'hA5, 0, 0, 0, 1, 0);
      checks++;
      if (r !== done_idx(0)) begin
         errors++; $display("FAIL basic_latency: got %0d exp %0d", r, done_idx(0));
      end
      checks++;
      if (dout !== m_dout) begin
         errors++; $display("FAIL basic_dout: got %h exp %h", dout, m_dout);
      end
      checks++;
      if ({rbf, perr, ferr, oe} !== {m_rbf, m_perr, m_ferr, m_oe}) begin
         errors++; $display("FAIL basic_flags: got %b exp %b", {rbf, perr, ferr, oe},
                            {m_rbf, m_perr, m_ferr, m_oe});
      end
      idle(8);
      do_read();
      checks++;
      if (rbf !== 1'b0) begin
         errors++; $display("FAIL basic_read: rbf got %b exp 0", rbf);
      end
   endtask

   task automatic test_parity();
      int r; logic [8:0] s;
      paren = 1; even = 1;
      send_frame(8'h03, 1, 0, 1, 1, -1, -1, r, s);
      model_done(8'h03, 1, 1, 0, 1, 0);
      idle(8);
      checks++;
      if ({dout, perr} !== {m_dout, m_perr}) begin
         errors++; $display("FAIL parity_good: got %h/%b exp %h/%b", dout, perr, m_dout, m_perr);
      end
      do_read();
      send_frame(8'h03, 1, 1, 1, 1, -1, -1, r, s);
      model_done(8'h03, 1, 1, 1, 1, 0);
      idle(8);
      checks++;
      if (perr !== m_perr) begin
         errors++; $display("FAIL parity_bad: perr got %b exp %b", perr, m_perr);
      end
      do_clr();
      checks++;
      if (perr !== m_perr) begin
         errors++; $display("FAIL parity_clr: perr got %b exp %b", perr, m_perr);
      end
      do_read();
      paren = 0;
   endtask

   task automatic test_overrun();
      int r; logic [8:0] s;
      send_frame(8'h11, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'h11, 0, 0, 0, 1, 0);
      idle(8);
      send_frame(8'h22, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'h22, 0, 0, 0, 1, 0);
      idle(8);
      checks++;
      if ({dout, oe, rbf} !== {m_dout, m_oe, m_rbf}) begin
         errors++; $display("FAIL overrun: dout/oe/rbf got %h/%b/%b exp %h/%b/%b",
                            dout, oe, rbf, m_dout, m_oe, m_rbf);
      end
      do_read();
      checks++;
      if (rbf !== m_rbf) begin
         errors++; $display("FAIL overrun_read: rbf got %b exp %b", rbf, m_rbf);
      end
      do_clr();
      send_frame(8'h11, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'h11, 0, 0, 0, 1, 0);
      idle(8);
      send_frame(8'h22, 0, 0, 1, 1, done_idx(0), -1, r, s);
      model_done(8'h22, 0, 0, 0, 1, 1);
      idle(8);
      checks++;
      if ({dout, rbf, oe} !== {m_dout, m_rbf, m_oe}) begin
         errors++; $display("FAIL overrun_same_cycle: dout/rbf/oe got %h/%b/%b exp %h/%b/%b",
                            dout, rbf, oe, m_dout, m_rbf, m_oe);
      end
      do_read();
   endtask

   task automatic test_glitch();
      int r; logic [8:0] s;
      serin = 0;
      repeat (4) @(negedge clk);
      idle(40);
      checks++;
      if ({rbf, ferr} !== 2'b00) begin
         errors++; $display("FAIL glitch_flags: rbf/ferr got %b exp 00", {rbf, ferr});
      end
      send_frame(8'h3C, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'h3C, 0, 0, 0, 1, 0);
      idle(8);
      checks++;
      if ({dout, rbf} !== {m_dout, m_rbf}) begin
         errors++; $display("FAIL glitch_next: got %h/%b exp %h/%b", dout, rbf, m_dout, m_rbf);
      end
      do_read();
   endtask

   task automatic test_break();
      int r; logic [8:0] s;
      for (int c = 0; c < 30 * OS; c++) begin
         serin = 0; bx16 = 1;
         u2drd = (c == 220);
         @(negedge clk);
         if (c == 200) begin
            checks++;
            if ({dout, rbf, ferr, rxbrk} !== {8'h00, 3'b111}) begin
               errors++; $display("FAIL break_hold: dout/rbf/ferr/rxbrk got %h/%b exp 00/111",
                                  dout, {rbf, ferr, rxbrk});
            end
         end
      end
      u2drd = 0;
      m_dout = 8'h00; m_rbf = 0; m_ferr = 1; m_brk = 1;
      checks++;
      if ({rbf, rxbrk} !== {m_rbf, m_brk}) begin
         errors++; $display("FAIL break_single: rbf/rxbrk got %b exp %b", {rbf, rxbrk}, {m_rbf, m_brk});
      end
      idle(8);
      m_brk = 0;
      checks++;
      if (rxbrk !== m_brk) begin
         errors++; $display("FAIL break_release: rxbrk got %b exp %b", rxbrk, m_brk);
      end
      do_clr();
      send_frame(8'h5A, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'h5A, 0, 0, 0, 1, 0);
      idle(8);
      checks++;
      if ({dout, rbf, ferr} !== {m_dout, m_rbf, m_ferr}) begin
         errors++; $display("FAIL break_next: got %h/%b/%b exp %h/%b/%b",
                            dout, rbf, ferr, m_dout, m_rbf, m_ferr);
      end
      do_read();
   endtask

   task automatic test_rxpol_reset();
      int r; logic [8:0] s;
      rxpol = 1;
      idle(40);
      send_frame(8'hC3, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'hC3, 0, 0, 0, 1, 0);
      idle(8);
      checks++;
      if ({dout, rbf} !== {m_dout, m_rbf}) begin
         errors++; $display("FAIL rxpol_dout: got %h/%b exp %h/%b", dout, rbf, m_dout, m_rbf);
      end
      rxpol = 0;
      idle(40);
      // Reset mid data bit 4; the rest of 0xF5 stays at mark so nothing follows.
      send_frame(8'hF5, 0, 0, 1, 1, -1, OS * 5 + 8, r, s);
      model_reset();
      checks++;
      if (s !== {m_dout, m_rbf}) begin
         errors++; $display("FAIL reset_midframe: dout/rbf got %h/%b exp %h/%b",
                            s[8:1], s[0], m_dout, m_rbf);
      end
      idle(8);
      checks++;
      if (rbf !== m_rbf) begin
         errors++; $display("FAIL reset_tail: rbf got %b exp %b", rbf, m_rbf);
      end
      send_frame(8'h96, 0, 0, 1, 1, -1, -1, r, s);
      model_done(8'h96, 0, 0, 0, 1, 0);
      idle(8);
      checks++;
      if ({dout, rbf} !== {m_dout, m_rbf}) begin
         errors++; $display("FAIL reset_next: got %h/%b exp %h/%b", dout, rbf, m_dout, m_rbf);
      end
      do_read();
   endtask

   task automatic test_random();
      int r, div, rd_at; logic [8:0] s;
      logic [7:0] d; bit par, ev, pb, stop, rd_same;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(1, 0) == 1) do_read();
         if ($urandom_range(3, 0) == 0) do_clr();
         d     = 8'($urandom);
         if ($urandom_range(5, 0) == 0) d = 8'h00;
         par   = $urandom_range(1, 0) == 1;
         ev    = $urandom_range(1, 0) == 1;
         pb    = good_parity(d, ev) ^ ($urandom_range(3, 0) == 0);
         stop  = $urandom_range(4, 0) != 0;
         div   = $urandom_range(3, 1);
         rd_same = (div == 1) && ($urandom_range(5, 0) == 0);
         rd_at = rd_same ? done_idx(par) : -1;
         paren = par; even = ev;
         send_frame(d, par, pb, stop, div, rd_at, -1, r, s);
         model_done(d, par, ev, pb, stop, rd_same);
         checks++;
         if ({dout, rbf, perr, ferr, oe, rxbrk} !== {m_dout, m_rbf, m_perr, m_ferr, m_oe, m_brk}) begin
            errors++;
            $display("FAIL random_%0d: dout/flags got %h/%b exp %h/%b", n, dout,
                     {rbf, perr, ferr, oe, rxbrk}, m_dout, {m_rbf, m_perr, m_ferr, m_oe, m_brk});
         end
         idle(10);
         m_brk = 0;
         checks++;
         if (rxbrk !== m_brk) begin
            errors++; $display("FAIL random_brk_%0d: rxbrk got %b exp %b", n, rxbrk, m_brk);
         end
      end
      paren = 0;
   endtask

   initial begin
      reset = 1; serin = 1; rxpol = 0; bx16 = 1; paren = 0; even = 0; u2drd = 0; clrerr = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_basic();
      test_parity();
      test_overrun();
      test_glitch();
      test_break();
      test_rxpol_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
